// File: rtl/block_ram_sp_pkg.sv
// Shared sizing constants for control-path storage built on block_ram_sp.
// The operand stack instantiates the RAM with these defaults.
package block_ram_sp_pkg;

  localparam int STACK_WORD_W = 8;
  localparam int STACK_DEPTH  = 65536;

endpackage

// File: rtl/block_ram_sp.sv
// Single-port synchronous RAM with a registered, read-first output.
// Out-of-range addresses (non-power-of-two depth only) drop writes and read as zero.
module block_ram_sp
  import block_ram_sp_pkg::*;
#(
  parameter  int DATA = STACK_WORD_W,
  parameter  int SIZE = STACK_DEPTH,
  localparam int AW   = $clog2(SIZE)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            write_enable,
  input  logic [DATA-1:0] data,
  input  logic [AW-1:0]   addr,
  output logic [DATA-1:0] data_out
);

  // One extra bit so a depth of exactly 2**AW still compares correctly.
  localparam logic [AW:0] SIZE_EXT = (AW + 1)'(SIZE);

  logic [DATA-1:0] mem_q [SIZE] = '{default: '0};
  logic [DATA-1:0] rd_q;
  logic            rd_valid_q;
  logic            in_range;

  assign in_range = ({1'b0, addr} < SIZE_EXT);

  // Array write and registered read share one block so the tools infer block RAM.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (in_range) begin
        rd_q <= mem_q[addr];
        if (write_enable) begin
          mem_q[addr] <= data;
        end
      end else begin
        rd_q <= '0;
      end
    end
  end

  // Reset lives apart from the array; it masks the output until the first real read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= 1'b1;
    end
  end

  assign data_out = rd_valid_q ? rd_q : '0;

endmodule

// File: tb/tb_block_ram_sp.sv
// Randomised bench for block_ram_sp: a default 8x65536 instance and a 16x100 instance,
// each compared every cycle against an associative-array memory model.
module tb_block_ram_sp;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        we_a = 1'b0;
  logic [7:0]  data_a = '0;
  logic [15:0] addr_a = '0;
  logic [7:0]  dout_a;

  logic        we_b = 1'b0;
  logic [15:0] data_b = '0;
  logic [6:0]  addr_b = '0;
  logic [15:0] dout_b;

  int n_pass  = 0;
  int n_total = 0;

  bit [7:0]  ma [int];
  bit [15:0] mb [int];
  logic [7:0]  exp_a = '0;
  logic [15:0] exp_b = '0;

  always #5 clk = ~clk;

  block_ram_sp u_dut_a (
    .clk          (clk),
    .rst_n        (rst_n),
    .write_enable (we_a),
    .data         (data_a),
    .addr         (addr_a),
    .data_out     (dout_a)
  );

  block_ram_sp #(.DATA(16), .SIZE(100)) u_dut_b (
    .clk          (clk),
    .rst_n        (rst_n),
    .write_enable (we_b),
    .data         (data_b),
    .addr         (addr_b),
    .data_out     (dout_b)
  );

  function automatic logic [7:0] rd_a(int a);
    return ma.exists(a) ? ma[a] : 8'h00;
  endfunction

  function automatic logic [15:0] rd_b(int a);
    if (a >= 100) return 16'h0000;
    return mb.exists(a) ? mb[a] : 16'h0000;
  endfunction

  // Reference behaviour: read-first, reset gates the edge, out-of-range reads zero.
  always @(posedge clk) begin
    if (rst_n) begin
      exp_a = rd_a(int'(addr_a));
      if (we_a) ma[int'(addr_a)] = data_a;
      exp_b = rd_b(int'(addr_b));
      if (we_b && int'(addr_b) < 100) mb[int'(addr_b)] = data_b;
    end
  end

  always @(negedge rst_n) begin
    exp_a = '0;
    exp_b = '0;
  end

  task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    chk("model_a", {8'h00, dout_a}, {8'h00, exp_a});
    chk("model_b", dout_b, exp_b);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) tick();
    chk("reset_a", {8'h00, dout_a}, 16'h0000);
    chk("reset_b", dout_b, 16'h0000);
    rst_n = 1'b1;
    addr_a = 16'h0000;
    tick();
    chk("zero_init_a0", {8'h00, dout_a}, 16'h0000);

    we_a = 1'b1; addr_a = 16'h0010; data_a = 8'hA5; tick();
    addr_a = 16'hFFFF; data_a = 8'h3C; tick();
    we_a = 1'b0; addr_a = 16'h0010; tick();
    chk("read_0010", {8'h00, dout_a}, 16'h00A5);
    addr_a = 16'hFFFF; tick();
    chk("read_ffff", {8'h00, dout_a}, 16'h003C);

    we_a = 1'b1; addr_a = 16'h0020; data_a = 8'h11; tick();
    data_a = 8'h22; tick();
    chk("collision_old", {8'h00, dout_a}, 16'h0011);
    we_a = 1'b0; tick();
    chk("collision_new", {8'h00, dout_a}, 16'h0022);

    we_a = 1'b1;
    for (int i = 0; i < 4; i++) begin
      addr_a = 16'h0100 + 16'(i); data_a = 8'(i + 1); tick();
    end
    we_a = 1'b0;
    for (int i = 0; i < 4; i++) begin
      addr_a = 16'h0100 + 16'(i); tick();
      chk("burst_read", {8'h00, dout_a}, 16'(i + 1));
    end

    we_a = 1'b1; addr_a = 16'h0005; data_a = 8'h7E; tick();
    we_a = 1'b0; addr_a = 16'h0000; tick();
    #2 rst_n = 1'b0;
    #1 chk("async_reset_a", {8'h00, dout_a}, 16'h0000);
    tick();
    rst_n = 1'b1; addr_a = 16'h0005; tick();
    chk("mem_survives_reset", {8'h00, dout_a}, 16'h007E);

    addr_b = 7'd99; tick();
    chk("b_99_initial", dout_b, 16'h0000);
    we_b = 1'b1; data_b = 16'h1234; tick();
    addr_b = 7'd100; data_b = 16'hBEEF; tick();
    we_b = 1'b0; tick();
    chk("b_oob_read", dout_b, 16'h0000);
    addr_b = 7'd99; tick();
    chk("b_99_intact", dout_b, 16'h1234);

    for (int n = 0; n < 3000; n++) begin
      we_a = ($urandom_range(0, 1) == 1);
      case ($urandom_range(0, 3))
        0:       addr_a = 16'hFFFF;
        1:       addr_a = 16'($urandom);
        default: addr_a = 16'($urandom_range(0, 31));
      endcase
      data_a = 8'($urandom);
      we_b   = ($urandom_range(0, 1) == 1);
      addr_b = 7'($urandom_range(90, 127));
      if ($urandom_range(0, 3) == 0) addr_b = 7'($urandom_range(0, 15));
      data_b = 16'($urandom);
      rst_n  = ($urandom_range(0, 99) != 0);
      tick();
    end
    rst_n = 1'b1;
    we_a = 1'b0; we_b = 1'b0;
    tick();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
